// File: rtl/iob_clint_if.sv
// Native valid/ready register bus used by iob_clint.
// The master drives the request; the slave returns ready and rdata one cycle later.
interface iob_clint_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid,
        output address,
        output wdata,
        output wstrb,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  address,
        input  wdata,
        input  wstrb,
        output rdata,
        output ready
    );
endinterface

// File: rtl/iob_clint.sv
// RISC-V core-local interruptor: shared 64-bit mtime driven by an external rtc,
// per-hart mtimecmp/msip registers and registered mtip/msip interrupt outputs.
module iob_clint #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rtc,
    iob_clint_if.slave         bus,
    output logic [N_CORES-1:0] mtip,
    output logic [N_CORES-1:0] msip
);

    localparam logic [ADDR_W-1:0] MtimeLoAddr = ADDR_W'(32'hBFF8);
    localparam logic [ADDR_W-1:0] MtimeHiAddr = ADDR_W'(32'hBFFC);

    logic [1:0]          rtc_sync_q, rtc_sync_d;
    logic                rtc_prev_q, rtc_prev_d;
    logic                tick;
    logic [63:0]         mtime_q, mtime_d;
    logic [63:0]         mtimecmp_q [N_CORES];
    logic [63:0]         mtimecmp_d [N_CORES];
    logic [N_CORES-1:0]  msip_q, msip_d;
    logic [N_CORES-1:0]  mtip_q, mtip_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_en, wr_en;

    function automatic logic [31:0] merge_bytes(input logic [31:0]         old_w,
                                                input logic [DATA_W-1:0]   new_w,
                                                input logic [DATA_W/8-1:0] strb);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rtc_sync_d = {rtc_sync_q[0], rtc};
        rtc_prev_d = rtc_sync_q[1];
        tick       = rtc_sync_q[1] & ~rtc_prev_q;

        rd_en   = bus.valid & (bus.wstrb == '0);
        wr_en   = bus.valid & (bus.wstrb != '0);
        ready_d = bus.valid;

        // Unmapped reads return zero; mapped decodes below override.
        rdata_d    = rd_en ? '0 : rdata_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;

        // A bus write to mtime replaces this cycle's increment entirely.
        if (bus.address == MtimeLoAddr) begin
            if (rd_en) rdata_d = mtime_q[31:0];
            if (wr_en) mtime_d = {mtime_q[63:32],
                                  merge_bytes(mtime_q[31:0], bus.wdata, bus.wstrb)};
        end
        if (bus.address == MtimeHiAddr) begin
            if (rd_en) rdata_d = mtime_q[63:32];
            if (wr_en) mtime_d = {merge_bytes(mtime_q[63:32], bus.wdata, bus.wstrb),
                                  mtime_q[31:0]};
        end

        for (int i = 0; i < N_CORES; i++) begin
            if (bus.address == ADDR_W'(4 * i)) begin
                if (rd_en) rdata_d = DATA_W'(msip_q[i]);
                if (wr_en && bus.wstrb[0]) msip_d[i] = bus.wdata[0];
            end
            if (bus.address == ADDR_W'(32'h4000 + 8 * i)) begin
                if (rd_en) rdata_d = mtimecmp_q[i][31:0];
                if (wr_en) mtimecmp_d[i][31:0] =
                    merge_bytes(mtimecmp_q[i][31:0], bus.wdata, bus.wstrb);
            end
            if (bus.address == ADDR_W'(32'h4004 + 8 * i)) begin
                if (rd_en) rdata_d = mtimecmp_q[i][63:32];
                if (wr_en) mtimecmp_d[i][63:32] =
                    merge_bytes(mtimecmp_q[i][63:32], bus.wdata, bus.wstrb);
            end
        end

        for (int i = 0; i < N_CORES; i++) begin
            mtip_d[i] = (mtime_q >= mtimecmp_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rtc_sync_q <= '0;
            rtc_prev_q <= 1'b0;
            mtime_q    <= '0;
            for (int i = 0; i < N_CORES; i++) mtimecmp_q[i] <= '1;
            msip_q     <= '0;
            mtip_q     <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rtc_sync_q <= rtc_sync_d;
            rtc_prev_q <= rtc_prev_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign mtip      = mtip_q;
    assign msip      = msip_q;

endmodule

// File: tb/tb_iob_clint.sv
// Directed bench for iob_clint: requests push expected responses to a scoreboard,
// a monitor pops and checks them whenever ready is seen.
module tb_iob_clint;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int N_CORES = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rtc = 1'b0;
    logic [N_CORES-1:0] mtip;
    logic [N_CORES-1:0] msip;

    iob_clint_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_clint #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .N_CORES(N_CORES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rtc (rtc),
        .bus (bus),
        .mtip(mtip),
        .msip(msip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [15:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   errors = 0;
    logic acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic req(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = a;
        bus.wdata   = wd;
        bus.wstrb   = st;
        e.is_read   = (st == 4'h0);
        e.addr      = a;
        e.exp       = exp;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st);
        req(a, wd, st, 32'h0);
        idle();
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp);
        req(a, 32'h0, 4'h0, exp);
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic rtc_pulse();
        @(negedge clk);
        rtc = 1'b1;
        repeat (4) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: ready must follow each accepted request by exactly one cycle.
    initial begin
        exp_t e;
        acc = 1'b0;
        forever begin
            @(posedge clk);
            acc = bus.valid & ~rst;
            @(negedge clk);
            if (acc || bus.ready) check("ready_timing", bus.ready, acc);
            if (bus.ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL sb_empty: got ready with no outstanding request");
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) check($sformatf("rd_%04h", e.addr), bus.rdata, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen_at;
        bus.valid   = 1'b0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_mtip", mtip, 2'b00);
        check("reset_msip", msip, 2'b00);
        check("reset_ready", bus.ready, 1'b0);
        check("reset_rdata", bus.rdata, 32'h0);

        // Request while in reset is dropped.
        bus.valid   = 1'b1;
        bus.address = 16'hBFF8;
        @(negedge clk);
        rst       = 1'b0;
        bus.valid = 1'b0;

        // Back-to-back reads of the reset state.
        req(16'hBFF8, 32'h0, 4'h0, 32'h0000_0000);
        req(16'hBFFC, 32'h0, 4'h0, 32'h0000_0000);
        req(16'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF);
        req(16'h400C, 32'h0, 4'h0, 32'hFFFF_FFFF);
        req(16'h0000, 32'h0, 4'h0, 32'h0000_0000);
        req(16'h0100, 32'h0, 4'h0, 32'h0000_0000);
        idle();
        drain();

        // Byte-enable merge on mtimecmp high word.
        wr(16'h4004, 32'hAABB_CCDD, 4'h2);
        rd(16'h4004, 32'hFFFF_CCFF);
        wr(16'h0100, 32'h1234_5678, 4'hF);
        rd(16'h0100, 32'h0);

        // Timer interrupt at mtime == 20.
        wr(16'h4000, 32'd20, 4'hF);
        wr(16'h4004, 32'd0, 4'hF);
        repeat (19) rtc_pulse();
        check("mtip_before_20", mtip, 2'b00);
        @(negedge clk);
        rtc     = 1'b1;
        seen_at = '0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            seen_at[n] = mtip[0];
        end
        check("mtip_rise_within_4", |seen_at, 1'b1);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        check("mtip_stays_high", mtip, 2'b01);
        rd(16'hBFF8, 32'd20);
        rd(16'hBFFC, 32'd0);

        // Software interrupts.
        wr(16'h0000, 32'h1, 4'hF);
        check("msip_set0", msip, 2'b01);
        wr(16'h0004, 32'h1, 4'hF);
        check("msip_set1", msip, 2'b11);
        rd(16'h0000, 32'h1);
        wr(16'h0000, 32'h0, 4'hF);
        check("msip_clr0", msip, 2'b10);
        wr(16'h0000, 32'hFFFF_FFFE, 4'hF);
        check("msip_bit0_only", msip, 2'b10);
        wr(16'h0004, 32'h0, 4'hF);
        wr(16'h0000, 32'h1, 4'h2);
        check("msip_strb_byte1", msip, 2'b00);
        check("mtip_with_msip", mtip, 2'b01);

        // Raising mtimecmp: mtip falls two cycles after the write.
        req(16'h4000, 32'd800, 4'hF, 32'h0);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
        check("mtip_lag", mtip[0], 1'b1);
        @(negedge clk);
        check("mtip_fall", mtip[0], 1'b0);

        // Monotonic mtime reads after clearing the low word.
        wr(16'hBFF8, 32'h0, 4'hF);
        repeat (3) rtc_pulse();
        rd(16'hBFF8, 32'd3);
        rtc_pulse();
        rd(16'hBFF8, 32'd4);
        rd(16'hBFFC, 32'd0);

        // 64-bit wrap.
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check("mtip_at_max", mtip, 2'b11);
        rtc_pulse();
        rd(16'hBFF8, 32'h0);
        rd(16'hBFFC, 32'h0);
        check("mtip_after_wrap", mtip, 2'b00);

        // Write coinciding with an rtc increment wins.
        @(negedge clk);
        rtc = 1'b1;
        @(posedge clk);
        @(posedge clk);
        req(16'hBFF8, 32'h1234_5678, 4'hF, 32'h0);
        idle();
        rd(16'hBFF8, 32'h1234_5678);
        rd(16'hBFFC, 32'h0);
        rtc = 1'b0;
        repeat (4) @(negedge clk);

        // Reset again restores defaults.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rereset_mtip", mtip, 2'b00);
        rd(16'hBFF8, 32'h0);
        rd(16'h4000, 32'hFFFF_FFFF);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
